// File: rtl/tap_pkg.sv
// -----------------------------------------------------------------------------
// tap_pkg
// Shared TAP definitions used by the boundary-scan register and by the TAP
// instruction decoder.
//   bs_instr_t             : 3-bit boundary-scan instruction encoding
//   instr_captures_func()  : instruction loads functional values on Capture-DR
//   instr_drives_pads()    : instruction routes the update register to func_o
// -----------------------------------------------------------------------------
package tap_pkg;

  localparam int BS_INSTR_W = 3;

  typedef enum logic [BS_INSTR_W-1:0] {
    EXTEST  = 3'b000,
    SAMPLE  = 3'b001,
    PRELOAD = 3'b010,
    CLAMP   = 3'b011,
    BYPASS  = 3'b111
  } bs_instr_t;

  // SAMPLE and EXTEST snapshot the functional signals into the shift cells.
  // PRELOAD and CLAMP keep whatever was shifted in earlier.
  function automatic logic instr_captures_func(input bs_instr_t instr);
    return (instr == SAMPLE) || (instr == EXTEST);
  endfunction

  // EXTEST and CLAMP take the pads away from the core and drive them from
  // the update register. Every other instruction leaves the pads transparent.
  function automatic logic instr_drives_pads(input bs_instr_t instr);
    return (instr == EXTEST) || (instr == CLAMP);
  endfunction

endpackage : tap_pkg

// File: rtl/tap_bs_lencheck.sv
// -----------------------------------------------------------------------------
// tap_bs_lencheck
// Counts Shift-DR cycles since the last Capture-DR and flags an update whose
// shift length differs from the chain length.
// Ports:
//   tck_i       : TAP clock, rising-edge active
//   trst_i      : asynchronous active-high reset
//   capture_i   : qualified capture (clears the counter)
//   shift_i     : qualified shift (increments, saturating at N_CELLS+1)
//   update_i    : qualified update (registers the length-error flag)
//   cnt_o       : current shift count
//   len_ok_o    : combinational, count equals N_CELLS right now
//   len_err_o   : registered result of the last update attempt
// The caller guarantees at most one of capture_i/shift_i/update_i is high.
// -----------------------------------------------------------------------------
module tap_bs_lencheck #(
  parameter  int N_CELLS = 8,
  localparam int CNT_W   = $clog2(N_CELLS + 2)
) (
  input  logic             tck_i,
  input  logic             trst_i,
  input  logic             capture_i,
  input  logic             shift_i,
  input  logic             update_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             len_ok_o,
  output logic             len_err_o
);

  // Saturating at N_CELLS+1 keeps "too many shifts" distinguishable from
  // "exactly right" without the counter ever wrapping back to N_CELLS.
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(N_CELLS + 1);
  localparam logic [CNT_W-1:0] CNT_GOOD = CNT_W'(N_CELLS);

  logic [CNT_W-1:0] cnt_reg;
  logic [CNT_W-1:0] cnt_next;
  logic             len_err_reg;
  logic             len_err_next;

  always_comb begin
    cnt_next = cnt_reg;
    if (capture_i) begin
      cnt_next = '0;
    end else if (shift_i && (cnt_reg != CNT_SAT)) begin
      cnt_next = cnt_reg + 1'b1;
    end
  end

  always_comb begin
    len_err_next = len_err_reg;
    if (update_i) begin
      len_err_next = (cnt_reg != CNT_GOOD);
    end
  end

  always_ff @(posedge tck_i or posedge trst_i) begin
    if (trst_i) begin
      cnt_reg     <= '0;
      len_err_reg <= 1'b0;
    end else begin
      cnt_reg     <= cnt_next;
      len_err_reg <= len_err_next;
    end
  end

  assign cnt_o     = cnt_reg;
  assign len_ok_o  = (cnt_reg == CNT_GOOD);
  assign len_err_o = len_err_reg;

endmodule : tap_bs_lencheck

// File: rtl/tap_bs_register.sv
// -----------------------------------------------------------------------------
// tap_bs_register
// IEEE 1149.1 style boundary-scan data register: N_CELLS shift cells feeding
// N_CELLS update latches, with a shift-length check that can veto updates.
// Ports:
//   tck_i        : TAP clock, all state changes on the rising edge
//   trst_i       : asynchronous active-high reset
//   sel_i        : boundary-scan register is the selected DR
//   instr_i      : current instruction (BYPASS/SAMPLE/PRELOAD/EXTEST/CLAMP)
//   captureDR_i  : Capture-DR strobe
//   shiftDR_i    : Shift-DR strobe
//   updateDR_i   : Update-DR strobe
//   tdi_i        : serial input into cell 0
//   func_i       : functional signals into the cells
//   func_o       : signals to pads/core (update register or pass-through)
//   tdo_o        : serial output from cell N_CELLS-1
//   shift_cnt_o  : shifts since last capture, saturating at N_CELLS+1
//   len_err_o    : last update attempt had a shift count != N_CELLS
// Parameters:
//   N_CELLS      : chain length, 2..64
//   STRICT_UPD   : 1 = suppress the update-register load on a bad length
// -----------------------------------------------------------------------------
module tap_bs_register
  import tap_pkg::*;
#(
  parameter  int N_CELLS    = 8,
  parameter  bit STRICT_UPD = 1'b1,
  localparam int CNT_W      = $clog2(N_CELLS + 2)
) (
  input  logic               tck_i,
  input  logic               trst_i,
  input  logic               sel_i,
  input  bs_instr_t          instr_i,
  input  logic               captureDR_i,
  input  logic               shiftDR_i,
  input  logic               updateDR_i,
  input  logic               tdi_i,
  input  logic [N_CELLS-1:0] func_i,
  output logic [N_CELLS-1:0] func_o,
  output logic               tdo_o,
  output logic [CNT_W-1:0]   shift_cnt_o,
  output logic               len_err_o
);

  // ---------------------------------------------------------------------------
  // Strobe qualification. The register only reacts while it is the selected
  // DR under a non-BYPASS instruction. If the TAP ever presents several
  // strobes at once, capture wins over shift, and shift wins over update.
  // ---------------------------------------------------------------------------
  logic active;
  logic capture_en;
  logic shift_en;
  logic update_en;
  logic capture_load;
  logic len_ok;
  logic ur_load;
  logic drive_ur;

  assign active     = sel_i && (instr_i != BYPASS);
  assign capture_en = active && captureDR_i;
  assign shift_en   = active && shiftDR_i  && !captureDR_i;
  assign update_en  = active && updateDR_i && !captureDR_i && !shiftDR_i;

  // PRELOAD/CLAMP captures still restart the length count but keep the cells.
  assign capture_load = capture_en && instr_captures_func(instr_i);

  // A non-strict build always loads. A strict build loads only after exactly
  // N_CELLS shifts, so a truncated or overrun scan never reaches the pads.
  assign ur_load  = update_en && (!STRICT_UPD || len_ok);

  assign drive_ur = instr_drives_pads(instr_i);

  // ---------------------------------------------------------------------------
  // Shift-length bookkeeping
  // ---------------------------------------------------------------------------
  tap_bs_lencheck #(
    .N_CELLS (N_CELLS)
  ) u_lencheck (
    .tck_i     (tck_i),
    .trst_i    (trst_i),
    .capture_i (capture_en),
    .shift_i   (shift_en),
    .update_i  (update_en),
    .cnt_o     (shift_cnt_o),
    .len_ok_o  (len_ok),
    .len_err_o (len_err_o)
  );

  // ---------------------------------------------------------------------------
  // Boundary-scan cells. Each cell owns one shift flop and one update flop.
  // Data enters at cell 0 and leaves from cell N_CELLS-1, so the first bit
  // shifted in ends up in the highest cell after a full scan.
  // ---------------------------------------------------------------------------
  logic [N_CELLS-1:0] sr_vec;
  logic [N_CELLS-1:0] ur_vec;

  for (genvar gi = 0; gi < N_CELLS; gi++) begin : g_cell
    logic shift_in;
    logic sr_bit_reg;
    logic sr_bit_next;
    logic ur_bit_reg;
    logic ur_bit_next;

    if (gi == 0) begin : g_head
      assign shift_in = tdi_i;
    end else begin : g_body
      assign shift_in = sr_vec[gi-1];
    end

    always_comb begin
      sr_bit_next = sr_bit_reg;
      if (capture_en) begin
        if (capture_load) begin
          sr_bit_next = func_i[gi];
        end
      end else if (shift_en) begin
        sr_bit_next = shift_in;
      end
    end

    always_comb begin
      ur_bit_next = ur_bit_reg;
      if (ur_load) begin
        ur_bit_next = sr_bit_reg;
      end
    end

    always_ff @(posedge tck_i or posedge trst_i) begin
      if (trst_i) begin
        sr_bit_reg <= 1'b0;
        ur_bit_reg <= 1'b0;
      end else begin
        sr_bit_reg <= sr_bit_next;
        ur_bit_reg <= ur_bit_next;
      end
    end

    assign sr_vec[gi] = sr_bit_reg;
    assign ur_vec[gi] = ur_bit_reg;

    // Pad mux follows the instruction even when the register is not selected,
    // so switching into EXTEST/CLAMP takes effect without waiting for a strobe.
    assign func_o[gi] = drive_ur ? ur_bit_reg : func_i[gi];
  end

  assign tdo_o = sr_vec[N_CELLS-1];

endmodule : tap_bs_register

// File: doc/tap_bs_register.md
TAP_BS_REGISTER -- requirements
Module: tap_bs_register

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset: tck_i input, trst_i input (trst_i=1 resets immediately, independent of tck_i).
REQ-002 The block SHALL have parameter N_CELLS, default 8, meaning the number of boundary-scan cells in the chain (legal range 2..64).
REQ-003 The block SHALL have parameter STRICT_UPD, default 1, meaning that an update is suppressed when the shift length is wrong.
REQ-004 The block SHALL have these ports, one per line:
- tck_i  in  1  TAP clock; all state changes on rising edge.
- trst_i  in  1  async active-high reset.
- sel_i  in  1  boundary-scan register selected as the active DR.
- instr_i  in  bs_instr_t  current instruction (BYPASS, SAMPLE, PRELOAD, EXTEST, CLAMP).
- captureDR_i  in  1  Capture-DR state strobe.
- shiftDR_i  in  1  Shift-DR state strobe.
- updateDR_i  in  1  Update-DR state strobe.
- tdi_i  in  1  serial data in (feeds cell 0).
- func_i  in  N_CELLS  functional (system) signals into cells.
- func_o  out  N_CELLS  signals driven to pads/core.
- tdo_o  out  1  serial data out (cell N_CELLS-1).
- shift_cnt_o  out  $clog2(N_CELLS+2)  shifts since last capture, saturating.
- len_err_o  out  1  last update attempt had shift count != N_CELLS.

Function
REQ-005 Internal state SHALL be shift register sr[N_CELLS-1:0], update register ur[N_CELLS-1:0], counter cnt, flag len_err.
REQ-006 Active operation SHALL require sel_i=1 and instr_i != BYPASS; otherwise sr, ur, cnt and len_err hold.
REQ-007 Strobe priority SHALL be capture > shift > update when more than one strobe is high in the same cycle; lower-priority strobes are ignored.
REQ-008 Capture SHALL load sr <= func_i for SAMPLE and EXTEST, leave sr unchanged for PRELOAD and CLAMP, and clear cnt to 0 for all active instructions.
REQ-009 Shift SHALL perform sr <= {sr[N_CELLS-2:0], tdi_i} and increment cnt, saturating at N_CELLS+1.
REQ-010 tdo_o SHALL equal sr[N_CELLS-1] combinationally; after N_CELLS shifts of bits b0 (first) .. bN-1, cell 0 holds bN-1 and cell N-1 holds b0.
REQ-011 Update SHALL load ur <= sr one tck_i edge after updateDR_i is sampled high, with ur visible on func_o in the same cycle that update completes.
REQ-012 Update SHALL register len_err <= (cnt != N_CELLS).
REQ-013 With STRICT_UPD=1 and cnt != N_CELLS, ur SHALL hold its value; with STRICT_UPD=0, ur SHALL always load.
REQ-014 func_o SHALL be combinational: ur when instr_i is EXTEST or CLAMP, func_i otherwise (SAMPLE, PRELOAD, BYPASS transparent), independent of sel_i.
REQ-015 A capture without a following update SHALL leave ur and func_o unchanged.
REQ-016 shift_cnt_o SHALL equal cnt and len_err_o SHALL equal len_err, both registered.
REQ-017 Changing instr_i mid-sequence SHALL take effect immediately on func_o and on the next strobe; no state is cleared.

Reset
REQ-018 trst_i=1 SHALL asynchronously clear sr, ur, cnt and len_err to 0; tdo_o=0, shift_cnt_o=0, len_err_o=0.
REQ-019 func_o SHALL follow REQ-014 during reset: 0 under EXTEST/CLAMP, func_i otherwise.
REQ-020 Reset asserted mid-shift SHALL abort the sequence; the next update after release SHALL see cnt counted from 0.

Structure
REQ-021 bs_instr_t (3-bit enum) and the instruction encodings SHALL reside in shared package tap_pkg, reused by the TAP instruction decoder.
REQ-022 The shift-length counter and len_err logic SHALL be sub-module tap_bs_lencheck (parameter N_CELLS); cell logic SHALL be generated inline.

Verification (N_CELLS=8)
REQ-023 The bench SHALL cover: reset with func_i=8'hFF under EXTEST -> func_o=8'h00, tdo_o=0, shift_cnt_o=0.
REQ-024 The bench SHALL cover: SAMPLE, func_i=8'hA5, capture then 8 shifts with tdi_i=0 -> tdo_o sequence 1,0,1,0,0,1,0,1 and func_o=8'hA5 throughout.
REQ-025 The bench SHALL cover: PRELOAD, shift 8'b1010_1111 LSB first, update, then EXTEST -> func_o[0]=1, func_o[1]=0 (MSBs), len_err_o=0, shift_cnt_o=8.
REQ-026 The bench SHALL cover: EXTEST, STRICT_UPD=1, capture, 7 shifts, update -> ur unchanged and len_err_o=1; repeat with STRICT_UPD=0 -> ur loads and len_err_o=1.
REQ-027 The bench SHALL cover: captureDR_i and shiftDR_i high together -> capture only and cnt=0; then 12 shifts -> shift_cnt_o saturates at 9.
REQ-028 The bench SHALL cover: trst_i pulsed after 4 of 8 shifts -> all state is 0 immediately; sel_i=0 or BYPASS with strobes -> no state change.
